// File: rtl/montador_senha.sv
// montador_senha: collects keypad digits into a senhaPac_t for the verifier.
// Optional backspace key (0xC) enabled by defining MONTADOR_BACKSPACE_EN.
package montador_pkg;
    localparam int SENHA_DIGITS = 20;
    typedef struct packed {
        logic [SENHA_DIGITS-1:0][3:0] digits;
    } senhaPac_t;
endpackage

module montador_senha
    import montador_pkg::*;
#(
    parameter int MAX_DIGITS     = 20,
    parameter int MIN_DIGITS     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       done_in,
    output senhaPac_t  senha_out,
    output logic       valid_out,
    output logic [4:0] digit_count,
    output logic       key_drop
);

    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] TO_M1 = IW'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] MAXC = 5'(MAX_DIGITS);
    localparam logic [4:0] MINC = 5'(MIN_DIGITS);

    typedef enum logic [1:0] {
        COLETA,
        ENVIA,
        ESPERA
    } state_t;

    state_t        r_state;
    state_t        w_next_state;
    senhaPac_t     r_senha;
    senhaPac_t     w_senha;
    logic [4:0]    r_count;
    logic [4:0]    w_count;
    logic [IW-1:0] r_idle;
    logic [IW-1:0] w_idle;
    logic          r_valid;
    logic          r_drop;
    logic          w_drop;

    logic w_is_dig;
    logic w_is_clr;
    logic w_is_ent;
    logic w_is_bsp;
    logic w_is_bad;

    assign w_is_dig = (key_code <= 4'h9);
    assign w_is_clr = (key_code == 4'hA);
    assign w_is_ent = (key_code == 4'hB);
`ifdef MONTADOR_BACKSPACE_EN
    assign w_is_bsp = (key_code == 4'hC);
`else
    assign w_is_bsp = 1'b0;
`endif
    assign w_is_bad = ~(w_is_dig | w_is_clr | w_is_ent | w_is_bsp);

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= COLETA;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: enter with enough digits sends, done returns to collect
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            COLETA: begin
                if (key_valid && w_is_ent && (r_count >= MINC)) begin
                    w_next_state = ENVIA;
                end
            end
            ENVIA: begin
                w_next_state = ESPERA;
            end
            ESPERA: begin
                if (done_in) begin
                    w_next_state = COLETA;
                end
            end
            default: begin
                w_next_state = COLETA;
            end
        endcase
    end

    // Buffer, count, idle timer and drop for the next cycle
    always_comb begin
        w_senha = r_senha;
        w_count = r_count;
        w_idle  = '0;
        w_drop  = 1'b0;
        unique case (r_state)
            COLETA: begin
                if (key_valid) begin
                    unique case (1'b1)
                        w_is_dig: begin
                            if (r_count < MAXC) begin
                                w_senha.digits[r_count] = key_code;
                                w_count = r_count + 5'd1;
                            end else begin
                                w_drop = 1'b1;
                            end
                        end
                        w_is_clr: begin
                            w_senha = '1;
                            w_count = '0;
                        end
                        w_is_ent: begin
                            if (r_count < MINC) begin
                                w_senha = '1;
                                w_count = '0;
                                w_drop  = 1'b1;
                            end
                        end
`ifdef MONTADOR_BACKSPACE_EN
                        w_is_bsp: begin
                            if (r_count != 5'd0) begin
                                w_senha.digits[r_count - 5'd1] = 4'hF;
                                w_count = r_count - 5'd1;
                            end else begin
                                w_drop = 1'b1;
                            end
                        end
`endif
                        w_is_bad: begin
                            w_drop = 1'b1;
                        end
                        default: begin
                            w_drop = 1'b1;
                        end
                    endcase
                end else if (r_count != 5'd0) begin
                    if (r_idle >= TO_M1) begin
                        w_senha = '1;
                        w_count = '0;
                    end else begin
                        w_idle = r_idle + 1'b1;
                    end
                end
            end
            ENVIA: begin
                w_drop = key_valid;
            end
            ESPERA: begin
                w_drop = key_valid;
                if (done_in) begin
                    w_senha = '1;
                    w_count = '0;
                end
            end
            default: begin
                w_senha = '1;
                w_count = '0;
            end
        endcase
    end

    // Registered outputs; valid is high exactly while in ENVIA
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_senha <= '1;
            r_count <= '0;
            r_idle  <= '0;
            r_valid <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_senha <= w_senha;
            r_count <= w_count;
            r_idle  <= w_idle;
            r_valid <= (w_next_state == ENVIA);
            r_drop  <= w_drop;
        end
    end

    assign senha_out   = r_senha;
    assign digit_count = r_count;
    assign valid_out   = r_valid;
    assign key_drop    = r_drop;

endmodule
